match_ctrl: RTL and testbench
=============================

// Module: match_ctrl
// PURPOSE
//  Parametrised match/round controller; successor of the single-round game FSM. Tracks HP,
//  invincibility frames, round timer and best-of-N round score for player and enemy.
//  Sits between the Player/Enemy/bullet blocks (hit, shield inputs) and the renderer (state, HP, score, timer).
//  Issues a one-cycle round-restart pulse so motion blocks re-home between rounds.
// PARAMETERS
//  HP_MAX        3   HP reloaded at every round start (>=1)
//  ROUNDS_TO_WIN 2   rounds a side must win to take the match (>=1)
//  IFRAME_FRM    30  invincibility length after damage, in frame_tick pulses (>=1)
//  TIME_LIMIT    60  round time, in sec_tick pulses (>=1)
//  END_FRM       90  ROUND_END hold time, in frame_tick pulses (>=1)
//  localparams: HW=$clog2(HP_MAX+1), RW=$clog2(ROUNDS_TO_WIN+1), TW=$clog2(TIME_LIMIT+1), IW=$clog2(IFRAME_FRM+1)
// PORTS
//  clk             in   1   system clock; single clock domain
//  rst_n           in   1   asynchronous active-low reset
//  select          in   1   start/confirm button (level; rising edge used)
//  pause           in   1   pause button (level; rising edge used)
//  frame_tick      in   1   1-cycle pulse per video frame
//  sec_tick        in   1   1-cycle pulse per second
//  player_hit      in   1   enemy bullet hit player this cycle
//  enemy_hit       in   1   player bullet hit enemy this cycle
//  player_shield   in   1   player defending
//  enemy_shield    in   1   enemy defending
//  o_state         out  3   0 START,1 PLAY,2 PAUSE,3 ROUND_END,4 WIN,5 LOSE
//  o_is_gaming     out  1   1 iff o_state==PLAY
//  o_player_hp     out  HW  player HP
//  o_enemy_hp      out  HW  enemy HP
//  o_player_rounds out  RW  rounds won by player
//  o_enemy_rounds  out  RW  rounds won by enemy
//  o_player_inv    out  1   player invincibility counter nonzero
//  o_enemy_inv     out  1   enemy invincibility counter nonzero
//  o_timer         out  TW  seconds left in round
//  o_round_rst     out  1   1-cycle pulse at every round start
// BEHAVIOUR
//  Reset: state START, HP=HP_MAX, rounds=0, inv counters=0, timer=TIME_LIMIT, o_round_rst=0, edge regs=0.
//  All outputs registered; an input sampled at edge k is reflected at edge k+1.
//  select/pause: rising edge = level high now, low the previous cycle; holding a button acts once.
//  START: select edge -> PLAY; reload HP, timer, clear rounds and inv, pulse o_round_rst.
//  PLAY: pause edge -> PAUSE; select ignored.
//   damage side X when X_hit & !X_shield & inv_X==0 & hp_X!=0: hp_X-=1, inv_X<=IFRAME_FRM.
//   inv_X decrements on frame_tick, saturating at 0; a damage load wins over a same-cycle decrement.
//   Simultaneous player and enemy hits are both applied in the same cycle.
//   timer decrements on sec_tick, saturating at 0.
//   Round end is evaluated on registered values (cycle after the last hit/tick): hp_P==0 | hp_E==0 | timer==0 -> ROUND_END.
//   Winner: exactly one hp 0 -> the other side. Timeout with both alive -> higher hp wins.
//   Draw (both hp 0, or equal hp at timeout) -> no round awarded.
//   The winning side's round count +1 on the PLAY->ROUND_END edge; the count never exceeds ROUNDS_TO_WIN.
//  PAUSE: timer, inv counters and hits frozen and ignored; pause edge -> PLAY, all values unchanged.
//  ROUND_END: hold END_FRM frame_ticks; hits ignored. Then:
//   player rounds==ROUNDS_TO_WIN -> WIN; enemy rounds==ROUNDS_TO_WIN -> LOSE.
//   Otherwise -> PLAY with HP and timer reloaded, inv cleared, and o_round_rst pulsed.
//  WIN/LOSE: values frozen; select edge -> START (rounds cleared only when the next START->PLAY occurs).
//  Undefined state encodings (6,7) -> START next cycle.
//  Async reset mid-match returns to the reset values immediately, regardless of state.
// TESTING
//  1 reset, select high 1 cycle -> o_state=1 next edge, hp=3/3, timer=60, o_round_rst=1 for exactly 1 cycle.
//  2 PLAY, player_hit held 5 cycles, no frame_tick -> player_hp 3->2 once, o_player_inv=1; after 30 frame_ticks inv=0 and next hit -> hp=1.
//  3 enemy_hit with enemy_shield=1 -> enemy_hp stays 3; player_hit+enemy_hit same cycle -> both hp 2.
//  4 enemy hp driven to 0 twice (ROUNDS_TO_WIN=2) -> ROUND_END, enemy_rounds=0 player_rounds 1 then 2; after 90 frame_ticks -> WIN(4); select -> START.
//  5 PLAY, pause edge, 10 sec_tick + hits -> timer/hp unchanged, state 2; pause edge -> PLAY; 60 sec_ticks with hp 2 vs 3 -> enemy round.
//  6 both hp 1, simultaneous hits -> both 0, ROUND_END, no round awarded; rst_n low in ROUND_END -> all reset values immediately.

Source files
------------

// File: rtl/match_ctrl.sv
// Best-of-N match/round controller: HP, invincibility frames, round timer and round score
// for player and enemy, with a one-cycle restart pulse at every round start.
module match_ctrl #(
  parameter int unsigned HP_MAX        = 3,
  parameter int unsigned ROUNDS_TO_WIN = 2,
  parameter int unsigned IFRAME_FRM    = 30,
  parameter int unsigned TIME_LIMIT    = 60,
  parameter int unsigned END_FRM       = 90,
  localparam int unsigned HW = $clog2(HP_MAX + 1),
  localparam int unsigned RW = $clog2(ROUNDS_TO_WIN + 1),
  localparam int unsigned TW = $clog2(TIME_LIMIT + 1),
  localparam int unsigned IW = $clog2(IFRAME_FRM + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          select,
  input  logic          pause,
  input  logic          frame_tick,
  input  logic          sec_tick,
  input  logic          player_hit,
  input  logic          enemy_hit,
  input  logic          player_shield,
  input  logic          enemy_shield,
  output logic [2:0]    o_state,
  output logic          o_is_gaming,
  output logic [HW-1:0] o_player_hp,
  output logic [HW-1:0] o_enemy_hp,
  output logic [RW-1:0] o_player_rounds,
  output logic [RW-1:0] o_enemy_rounds,
  output logic          o_player_inv,
  output logic          o_enemy_inv,
  output logic [TW-1:0] o_timer,
  output logic          o_round_rst
);

  localparam int unsigned EW = $clog2(END_FRM + 1);

  typedef enum logic [2:0] {
    StStart    = 3'd0,
    StPlay     = 3'd1,
    StPause    = 3'd2,
    StRoundEnd = 3'd3,
    StWin      = 3'd4,
    StLose     = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hp_p_q, hp_p_d, hp_e_q, hp_e_d;
  logic [RW-1:0] rnd_p_q, rnd_p_d, rnd_e_q, rnd_e_d;
  logic [IW-1:0] inv_p_q, inv_p_d, inv_e_q, inv_e_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [EW-1:0] end_cnt_q, end_cnt_d;
  logic          round_rst_q, round_rst_d;
  logic          sel_q, pau_q;

  logic sel_rise, pau_rise, p_zero, e_zero, round_over, p_wins, e_wins, dmg_p, dmg_e;

  assign sel_rise   = select & ~sel_q;
  assign pau_rise   = pause & ~pau_q;
  assign p_zero     = (hp_p_q == '0);
  assign e_zero     = (hp_e_q == '0);
  assign round_over = p_zero | e_zero | (timer_q == '0);
  // Timeout with both alive goes to the higher HP; equal HP or double KO awards nothing.
  assign p_wins     = (e_zero & ~p_zero) | (~p_zero & ~e_zero & (hp_p_q > hp_e_q));
  assign e_wins     = (p_zero & ~e_zero) | (~p_zero & ~e_zero & (hp_e_q > hp_p_q));
  assign dmg_p      = player_hit & ~player_shield & (inv_p_q == '0) & ~p_zero;
  assign dmg_e      = enemy_hit & ~enemy_shield & (inv_e_q == '0) & ~e_zero;

  always_comb begin
    state_d     = state_q;
    hp_p_d      = hp_p_q;
    hp_e_d      = hp_e_q;
    rnd_p_d     = rnd_p_q;
    rnd_e_d     = rnd_e_q;
    inv_p_d     = inv_p_q;
    inv_e_d     = inv_e_q;
    timer_d     = timer_q;
    end_cnt_d   = end_cnt_q;
    round_rst_d = 1'b0;
    case (state_q)
      StStart: begin
        if (sel_rise) begin
          state_d     = StPlay;
          hp_p_d      = HW'(HP_MAX);
          hp_e_d      = HW'(HP_MAX);
          timer_d     = TW'(TIME_LIMIT);
          inv_p_d     = '0;
          inv_e_d     = '0;
          rnd_p_d     = '0;
          rnd_e_d     = '0;
          round_rst_d = 1'b1;
        end
      end
      StPlay: begin
        if (round_over) begin
          state_d   = StRoundEnd;
          end_cnt_d = '0;
          if (p_wins && (rnd_p_q != RW'(ROUNDS_TO_WIN))) rnd_p_d = rnd_p_q + RW'(1);
          if (e_wins && (rnd_e_q != RW'(ROUNDS_TO_WIN))) rnd_e_d = rnd_e_q + RW'(1);
        end else if (pau_rise) begin
          state_d = StPause;
        end else begin
          // A damage load takes priority over the same-cycle frame decrement.
          if (dmg_p) begin
            hp_p_d  = hp_p_q - HW'(1);
            inv_p_d = IW'(IFRAME_FRM);
          end else if (frame_tick && (inv_p_q != '0)) begin
            inv_p_d = inv_p_q - IW'(1);
          end
          if (dmg_e) begin
            hp_e_d  = hp_e_q - HW'(1);
            inv_e_d = IW'(IFRAME_FRM);
          end else if (frame_tick && (inv_e_q != '0)) begin
            inv_e_d = inv_e_q - IW'(1);
          end
          if (sec_tick && (timer_q != '0)) timer_d = timer_q - TW'(1);
        end
      end
      StPause: begin
        if (pau_rise) state_d = StPlay;
      end
      StRoundEnd: begin
        if (frame_tick) begin
          if (end_cnt_q == EW'(END_FRM - 1)) begin
            if (rnd_p_q == RW'(ROUNDS_TO_WIN)) begin
              state_d = StWin;
            end else if (rnd_e_q == RW'(ROUNDS_TO_WIN)) begin
              state_d = StLose;
            end else begin
              state_d     = StPlay;
              hp_p_d      = HW'(HP_MAX);
              hp_e_d      = HW'(HP_MAX);
              timer_d     = TW'(TIME_LIMIT);
              inv_p_d     = '0;
              inv_e_d     = '0;
              round_rst_d = 1'b1;
            end
          end else begin
            end_cnt_d = end_cnt_q + EW'(1);
          end
        end
      end
      StWin, StLose: begin
        if (sel_rise) state_d = StStart;
      end
      default: state_d = StStart;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StStart;
      hp_p_q      <= HW'(HP_MAX);
      hp_e_q      <= HW'(HP_MAX);
      rnd_p_q     <= '0;
      rnd_e_q     <= '0;
      inv_p_q     <= '0;
      inv_e_q     <= '0;
      timer_q     <= TW'(TIME_LIMIT);
      end_cnt_q   <= '0;
      round_rst_q <= 1'b0;
      sel_q       <= 1'b0;
      pau_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_p_q      <= hp_p_d;
      hp_e_q      <= hp_e_d;
      rnd_p_q     <= rnd_p_d;
      rnd_e_q     <= rnd_e_d;
      inv_p_q     <= inv_p_d;
      inv_e_q     <= inv_e_d;
      timer_q     <= timer_d;
      end_cnt_q   <= end_cnt_d;
      round_rst_q <= round_rst_d;
      sel_q       <= select;
      pau_q       <= pause;
    end
  end

  assign o_state         = state_q;
  assign o_is_gaming     = (state_q == StPlay);
  assign o_player_hp     = hp_p_q;
  assign o_enemy_hp      = hp_e_q;
  assign o_player_rounds = rnd_p_q;
  assign o_enemy_rounds  = rnd_e_q;
  assign o_player_inv    = (inv_p_q != '0);
  assign o_enemy_inv     = (inv_e_q != '0);
  assign o_timer         = timer_q;
  assign o_round_rst     = round_rst_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed-vector bench for match_ctrl; expectations are queued by the stimulus process and
// compared against the DUT outputs by a separate monitor on the falling clock edge.
module tb_match_ctrl;

  localparam int F_STATE = 0, F_GAMING = 1, F_HPP = 2, F_HPE = 3, F_RP = 4, F_RE = 5;
  localparam int F_INVP = 6, F_INVE = 7, F_TIMER = 8, F_RRST = 9;

  typedef struct {
    string name;
    int    f;
    int    v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       select = 1'b0, pause = 1'b0, frame_tick = 1'b0, sec_tick = 1'b0;
  logic       player_hit = 1'b0, enemy_hit = 1'b0, player_shield = 1'b0, enemy_shield = 1'b0;
  logic [2:0] o_state;
  logic       o_is_gaming, o_player_inv, o_enemy_inv, o_round_rst;
  logic [1:0] o_player_hp, o_enemy_hp, o_player_rounds, o_enemy_rounds;
  logic [5:0] o_timer;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  match_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .select         (select),
    .pause          (pause),
    .frame_tick     (frame_tick),
    .sec_tick       (sec_tick),
    .player_hit     (player_hit),
    .enemy_hit      (enemy_hit),
    .player_shield  (player_shield),
    .enemy_shield   (enemy_shield),
    .o_state        (o_state),
    .o_is_gaming    (o_is_gaming),
    .o_player_hp    (o_player_hp),
    .o_enemy_hp     (o_enemy_hp),
    .o_player_rounds(o_player_rounds),
    .o_enemy_rounds (o_enemy_rounds),
    .o_player_inv   (o_player_inv),
    .o_enemy_inv    (o_enemy_inv),
    .o_timer        (o_timer),
    .o_round_rst    (o_round_rst)
  );

  always #5 clk = ~clk;

  function automatic int actual(int f);
    case (f)
      F_STATE:  return int'(o_state);
      F_GAMING: return int'(o_is_gaming);
      F_HPP:    return int'(o_player_hp);
      F_HPE:    return int'(o_enemy_hp);
      F_RP:     return int'(o_player_rounds);
      F_RE:     return int'(o_enemy_rounds);
      F_INVP:   return int'(o_player_inv);
      F_INVE:   return int'(o_enemy_inv);
      F_TIMER:  return int'(o_timer);
      default:  return int'(o_round_rst);
    endcase
  endfunction

  // Monitor: drains every expectation queued since the last rising edge.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    while (q.size() != 0) begin
      e = q.pop_front();
      a = actual(e.f);
      checks++;
      if (a != e.v) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.v);
      end
    end
  end

  task automatic expect_val(input string name, input int f, input int v);
    exp_t e;
    e.name = name;
    e.f    = f;
    e.v    = v;
    q.push_back(e);
  endtask

  task automatic expect_core(input string name, input int st, input int hpp, input int hpe,
                             input int rp, input int re, input int tmr, input int rrst);
    expect_val({name, ".state"}, F_STATE, st);
    expect_val({name, ".gaming"}, F_GAMING, (st == 1) ? 1 : 0);
    expect_val({name, ".hp_p"}, F_HPP, hpp);
    expect_val({name, ".hp_e"}, F_HPE, hpe);
    expect_val({name, ".rounds_p"}, F_RP, rp);
    expect_val({name, ".rounds_e"}, F_RE, re);
    expect_val({name, ".timer"}, F_TIMER, tmr);
    expect_val({name, ".round_rst"}, F_RRST, rrst);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    frame_tick = 1'b1;
    tick(n);
    frame_tick = 1'b0;
  endtask

  task automatic secs(input int n);
    sec_tick = 1'b1;
    tick(n);
    sec_tick = 1'b0;
  endtask

  task automatic press_select();
    select = 1'b1;
    tick(1);
    select = 1'b0;
  endtask

  task automatic hit(input logic p, input logic e);
    player_hit = p;
    enemy_hit  = e;
    tick(1);
    player_hit = 1'b0;
    enemy_hit  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset
    tick(3);
    expect_core("reset", 0, 3, 3, 0, 0, 60, 0);
    expect_val("reset.inv_p", F_INVP, 0);
    expect_val("reset.inv_e", F_INVE, 0);
    rst_n = 1'b1;
    tick(1);

    // Match A, round 1: start pulse, shield, simultaneous hits, iframes
    press_select();
    expect_core("start", 1, 3, 3, 0, 0, 60, 1);
    checks++;
    if (o_round_rst !== 1'b1) begin
      failures++;
      $display("FAIL start.direct_rrst: got %0b expected 1", o_round_rst);
    end
    tick(1);
    expect_val("start.rrst_one_cycle", F_RRST, 0);
    enemy_shield = 1'b1;
    hit(1'b0, 1'b1);
    enemy_shield = 1'b0;
    expect_val("shield.hp_e", F_HPE, 3);
    expect_val("shield.inv_e", F_INVE, 0);
    hit(1'b1, 1'b1);
    expect_val("both_hit.hp_p", F_HPP, 2);
    expect_val("both_hit.hp_e", F_HPE, 2);
    expect_val("both_hit.inv_p", F_INVP, 1);
    expect_val("both_hit.inv_e", F_INVE, 1);
    frames(30);
    expect_val("iframe_end.inv_p", F_INVP, 0);
    expect_val("iframe_end.inv_e", F_INVE, 0);
    player_hit = 1'b1;
    tick(5);
    player_hit = 1'b0;
    expect_val("held_hit.hp_p", F_HPP, 1);
    expect_val("held_hit.inv_p", F_INVP, 1);
    frames(30);
    hit(1'b0, 1'b1);
    expect_val("r1_e1.hp_e", F_HPE, 1);
    frames(30);
    hit(1'b0, 1'b1);
    expect_val("r1_ko.hp_e", F_HPE, 0);
    expect_val("r1_ko.state_still_play", F_STATE, 1);
    tick(1);
    expect_core("r1_end", 3, 1, 0, 1, 0, 60, 0);
    player_hit = 1'b1;
    enemy_hit  = 1'b1;
    frames(89);
    player_hit = 1'b0;
    enemy_hit  = 1'b0;
    expect_core("r1_hold", 3, 1, 0, 1, 0, 60, 0);
    frames(1);
    expect_core("r2_start", 1, 3, 3, 1, 0, 60, 1);
    expect_val("r2_start.inv_p", F_INVP, 0);

    // Round 2: held hit 3->2, iframe expiry, second hit, enemy KO
    player_hit = 1'b1;
    tick(5);
    player_hit = 1'b0;
    expect_val("r2_held.hp_p", F_HPP, 2);
    expect_val("r2_held.inv_p", F_INVP, 1);
    frames(29);
    expect_val("r2_inv29.inv_p", F_INVP, 1);
    frames(1);
    expect_val("r2_inv30.inv_p", F_INVP, 0);
    hit(1'b1, 1'b0);
    expect_val("r2_second.hp_p", F_HPP, 1);
    hit(1'b0, 1'b1);
    frames(30);
    hit(1'b0, 1'b1);
    frames(30);
    hit(1'b0, 1'b1);
    expect_val("r2_ko.hp_e", F_HPE, 0);
    tick(1);
    expect_core("r2_end", 3, 1, 0, 2, 0, 60, 0);
    frames(90);
    expect_core("win", 4, 1, 0, 2, 0, 60, 0);
    checks++;
    if (o_state !== 3'd4) begin
      failures++;
      $display("FAIL win.direct_state: got %0d expected 4", o_state);
    end
    select = 1'b1;
    tick(1);
    expect_val("win_to_start.state", F_STATE, 0);
    tick(3);
    expect_val("start_held_select.state", F_STATE, 0);
    expect_val("start_keeps_rounds.rp", F_RP, 2);
    select = 1'b0;
    tick(1);

    // Match B: pause freezes everything, timeout with hp 2 vs 3
    press_select();
    expect_core("mB_start", 1, 3, 3, 0, 0, 60, 1);
    pause = 1'b1;
    tick(1);
    expect_val("pause.state", F_STATE, 2);
    checks++;
    if (o_state !== 3'd2) begin
      failures++;
      $display("FAIL pause.direct_state: got %0d expected 2", o_state);
    end
    tick(2);
    player_hit = 1'b1;
    enemy_hit  = 1'b1;
    frame_tick = 1'b1;
    secs(10);
    player_hit = 1'b0;
    enemy_hit  = 1'b0;
    frame_tick = 1'b0;
    expect_core("paused_frozen", 2, 3, 3, 0, 0, 60, 0);
    pause = 1'b0;
    tick(1);
    pause = 1'b1;
    tick(1);
    pause = 1'b0;
    expect_core("resume", 1, 3, 3, 0, 0, 60, 0);
    hit(1'b1, 1'b0);
    expect_val("mB_hit.hp_p", F_HPP, 2);
    secs(59);
    expect_val("timer_1.timer", F_TIMER, 1);
    secs(1);
    expect_val("timer_0.timer", F_TIMER, 0);
    expect_val("timer_0.state", F_STATE, 1);
    tick(1);
    expect_core("timeout_end", 3, 2, 3, 0, 1, 0, 0);
    checks++;
    if (o_enemy_rounds !== 2'd1) begin
      failures++;
      $display("FAIL timeout_end.direct_re: got %0d expected 1", o_enemy_rounds);
    end
    frames(90);
    expect_core("mB_r2_start", 1, 3, 3, 0, 1, 60, 1);

    // Double KO draw, then async reset inside ROUND_END
    hit(1'b1, 1'b1);
    frames(30);
    hit(1'b1, 1'b1);
    frames(30);
    hit(1'b1, 1'b1);
    expect_core("double_ko", 1, 0, 0, 0, 1, 60, 0);
    tick(1);
    expect_core("draw_end", 3, 0, 0, 0, 1, 60, 0);
    tick(1);
    rst_n = 1'b0;
    #2;
    expect_core("async_rst", 0, 3, 3, 0, 0, 60, 0);
    expect_val("async_rst.inv_p", F_INVP, 0);
    expect_val("async_rst.inv_e", F_INVE, 0);
    checks++;
    if (o_state !== 3'd0) begin
      failures++;
      $display("FAIL async_rst.direct_state: got %0d expected 0", o_state);
    end
    tick(1);
    rst_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
